// File: rtl/datapath_seq_pkg.sv
// datapath_seq_pkg: shared enums and constants for the sequenced datapath.
// Command encodings, FSM states, status-bit positions and kind helpers.
package datapath_seq_pkg;

    typedef enum logic [1:0] {
        K_MOVI = 2'b00,
        K_MOV  = 2'b01,
        K_ALU  = 2'b10,
        K_CMP  = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_NOT = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    // Bit positions inside the {N, Z, V} status word.
    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int V_BIT = 0;

    function automatic logic writes_rd(kind_e k);
        return k != K_CMP;
    endfunction

    function automatic logic updates_flags(kind_e k);
        return (k == K_ALU) || (k == K_CMP);
    endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// datapath_seq_if: command handshake and result bus of datapath_seq.
// master = command issuer (cmd_* out), slave = datapath (ready/done/results out).
interface datapath_seq_if
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 8
);
    localparam int RIDX_W = $clog2(NREGS);

    logic              cmd_valid;
    logic              cmd_ready;
    kind_e             cmd_kind;
    aluop_e            cmd_aluop;
    shift_e            cmd_shift;
    logic [RIDX_W-1:0] cmd_rd;
    logic [RIDX_W-1:0] cmd_rn;
    logic [RIDX_W-1:0] cmd_rm;
    logic [IMM_W-1:0]  cmd_imm;
    logic              done;
    logic [WIDTH-1:0]  datapath_out;
    logic [2:0]        status;

    modport master (
        output cmd_valid, cmd_kind, cmd_aluop, cmd_shift,
        output cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        input  cmd_ready, done, datapath_out, status
    );

    modport slave (
        input  cmd_valid, cmd_kind, cmd_aluop, cmd_shift,
        input  cmd_rd, cmd_rn, cmd_rm, cmd_imm,
        output cmd_ready, done, datapath_out, status
    );

endinterface

// File: rtl/dps_alu.sv
// dps_alu: combinational B-shifter, ALU and N/Z/V generation.
// Ports: i_kind/i_op/i_shift select, i_a/i_b operands, i_imm pre-extended
// immediate; o_result, o_nzv {N,Z,V}, o_upd = status should be loaded.
module dps_alu
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  kind_e            i_kind,
    input  aluop_e           i_op,
    input  shift_e           i_shift,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_imm,
    output logic [WIDTH-1:0] o_result,
    output logic [2:0]       o_nzv,
    output logic             o_upd
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] w_bs;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_v;
    logic             w_sub_v;
    logic             w_v;

    always_comb begin
        w_bs = i_b;
        unique case (i_shift)
            SH_NONE: w_bs = i_b;
            SH_LSL1: w_bs = {i_b[MSB-1:0], 1'b0};
            SH_LSR1: w_bs = {1'b0, i_b[MSB:1]};
            SH_ASR1: w_bs = {i_b[MSB], i_b[MSB:1]};
        endcase
    end

    assign w_sum  = i_a + w_bs;
    assign w_diff = i_a - w_bs;

    // Signed overflow: operand signs agree (add) / differ (sub) and the
    // result sign departs from A.
    assign w_add_v = (i_a[MSB] == w_bs[MSB]) && (w_sum[MSB] != i_a[MSB]);
    assign w_sub_v = (i_a[MSB] != w_bs[MSB]) && (w_diff[MSB] != i_a[MSB]);

    always_comb begin
        o_result = '0;
        w_v      = 1'b0;
        unique case (i_kind)
            K_MOVI: o_result = i_imm;
            K_MOV:  o_result = w_bs;
            K_CMP: begin
                o_result = w_diff;
                w_v      = w_sub_v;
            end
            K_ALU: begin
                unique case (i_op)
                    OP_ADD: begin
                        o_result = w_sum;
                        w_v      = w_add_v;
                    end
                    OP_SUB: begin
                        o_result = w_diff;
                        w_v      = w_sub_v;
                    end
                    OP_AND: o_result = i_a & w_bs;
                    OP_NOT: o_result = ~w_bs;
                endcase
            end
        endcase
    end

    always_comb begin
        o_nzv        = '0;
        o_nzv[N_BIT] = o_result[MSB];
        o_nzv[Z_BIT] = (o_result == '0);
        o_nzv[V_BIT] = w_v;
    end

    assign o_upd = updates_flags(i_kind);

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: self-sequencing datapath, IDLE->RDA->RDB->EXEC->WB per command.
// Ports: clk, reset (async, active-high), bus (slave: cmd handshake, done,
// datapath_out = C register, status = {N,Z,V}).
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int IMM_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    datapath_seq_if.slave bus
);
    localparam int RIDX_W = $clog2(NREGS);

    state_e            r_state;
    state_e            w_next;

    kind_e             r_kind;
    aluop_e            r_op;
    shift_e            r_shift;
    logic [RIDX_W-1:0] r_rd;
    logic [RIDX_W-1:0] r_rn;
    logic [RIDX_W-1:0] r_rm;
    logic [IMM_W-1:0]  r_imm;

    logic [WIDTH-1:0]  r_rf [NREGS];
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_c;
    logic [2:0]        r_status;

    logic              w_ready;
    logic              w_ld_a;
    logic              w_ld_b;
    logic              w_ld_c;
    logic              w_done;
    logic              w_accept;
    logic              w_wr;
    logic [WIDTH-1:0]  w_imm_ext;
    logic [WIDTH-1:0]  w_result;
    logic [2:0]        w_nzv;
    logic              w_upd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next = S_RDA;
            S_RDA:   w_next = S_RDB;
            S_RDB:   w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_ld_a  = 1'b0;
        w_ld_b  = 1'b0;
        w_ld_c  = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE:  w_ready = 1'b1;
            S_RDA:   w_ld_a  = 1'b1;
            S_RDB:   w_ld_b  = 1'b1;
            S_EXEC:  w_ld_c  = 1'b1;
            S_WB:    w_done  = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = w_ready & bus.cmd_valid;
    assign w_wr     = w_done & writes_rd(r_kind);

    // Fields are latched at accept so the issuer may move on immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind  <= K_MOVI;
            r_op    <= OP_ADD;
            r_shift <= SH_NONE;
            r_rd    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_imm   <= '0;
        end else if (w_accept) begin
            r_kind  <= bus.cmd_kind;
            r_op    <= bus.cmd_aluop;
            r_shift <= bus.cmd_shift;
            r_rd    <= bus.cmd_rd;
            r_rn    <= bus.cmd_rn;
            r_rm    <= bus.cmd_rm;
            r_imm   <= bus.cmd_imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
        end else begin
            if (w_ld_a) r_a <= r_rf[r_rn];
            if (w_ld_b) r_b <= r_rf[r_rm];
            if (w_ld_c) begin
                r_c <= w_result;
                if (w_upd) r_status <= w_nzv;
            end
        end
    end

    // Write happens leaving WB, after both sources were read, so
    // rd aliasing rn/rm always sees the old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (w_wr) begin
            r_rf[r_rd] <= r_c;
        end
    end

    assign w_imm_ext = WIDTH'($signed(r_imm));

    dps_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_kind   (r_kind),
        .i_op     (r_op),
        .i_shift  (r_shift),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (w_imm_ext),
        .o_result (w_result),
        .o_nzv    (w_nzv),
        .o_upd    (w_upd)
    );

    assign bus.cmd_ready    = w_ready;
    assign bus.done         = w_done;
    assign bus.datapath_out = r_c;
    assign bus.status       = r_status;

endmodule
